// File: rtl/complex_mult_sched.sv
// complex_mult_sched: round-robin scheduler that shares one pipelined complex
// multiplier among N_REQ requesters. A tag pipe, matched to the multiplier
// latency and frozen together with it, routes each product back to its issuer.
//
// Operand layout (complex32): [31:16] real, [15:0] imag, two's complement.
// Result layout  (complex64): [63:32] real, [31:0] imag, two's complement.
//
// Tag pipe stage | meaning
//   0            | operands presented to the multiplier one cycle ago
//   PIPE_NUM-1   | product currently on mult_z; strobes rsp_valid when mult_en
module complex_mult_sched #(
    parameter int N_REQ    = 4,
    parameter int PIPE_NUM = 10,
    parameter int MAX_OUT  = 4,
    localparam int IDW = $clog2(N_REQ),
    localparam int CW  = $clog2(MAX_OUT + 1),
    localparam int IFW = $clog2(N_REQ * MAX_OUT + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0][31:0] req_a,
    input  logic [N_REQ-1:0][31:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   mult_en,
    output logic [31:0]            mult_a,
    output logic [31:0]            mult_b,
    input  logic [63:0]            mult_z,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [63:0]            rsp_z,
    output logic [IFW-1:0]         inflight
);

    logic [PIPE_NUM-1:0]          tag_valid_q, tag_valid_d;
    logic [PIPE_NUM-1:0][IDW-1:0] tag_id_q, tag_id_d;
    logic [N_REQ-1:0][CW-1:0]     cnt_q, cnt_d;
    logic [IDW-1:0]               rr_q, rr_d;
    logic [IFW-1:0]               inflight_q, inflight_d;

    logic [N_REQ-1:0] eligible;
    logic             grant_vld;
    logic [IDW-1:0]   grant_id;
    logic             accept;
    logic             rsp_fire;
    int               cand;

    // Eligibility and round-robin pick; scanning farthest-first lets the
    // nearest eligible requester after the pointer overwrite the others.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req_valid[i] && (cnt_q[i] < CW'(MAX_OUT));
        end
        for (int k = N_REQ; k >= 1; k--) begin
            cand = (int'(rr_q) + k) % N_REQ;
            if (eligible[IDW'(cand)]) begin
                grant_vld = 1'b1;
                grant_id  = IDW'(cand);
            end
        end
    end

    // Accept handshake, operand mux (zero bubbles) and result routing
    always_comb begin
        mult_en   = ~stall;
        accept    = grant_vld & ~stall & ~rst;
        req_ready = '0;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
        mult_a    = accept ? req_a[grant_id] : 32'd0;
        mult_b    = accept ? req_b[grant_id] : 32'd0;
        rsp_fire  = tag_valid_q[PIPE_NUM-1] & mult_en;
        rsp_valid = '0;
        if (rsp_fire) begin
            rsp_valid[tag_id_q[PIPE_NUM-1]] = 1'b1;
        end
        rsp_id    = tag_id_q[PIPE_NUM-1];
        rsp_z     = mult_z;
        inflight  = inflight_q;
    end

    // Next state: tag shift tracks multiplier hold, counters net accept vs. response
    always_comb begin
        tag_valid_d = tag_valid_q;
        tag_id_d    = tag_id_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        inflight_d  = inflight_q;
        if (mult_en) begin
            for (int s = PIPE_NUM - 1; s > 0; s--) begin
                tag_valid_d[s] = tag_valid_q[s-1];
                tag_id_d[s]    = tag_id_q[s-1];
            end
            tag_valid_d[0] = accept;
            tag_id_d[0]    = accept ? grant_id : '0;
        end
        if (accept) begin
            rr_d = grant_id;
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (accept && (grant_id == IDW'(i)) && !rsp_valid[i]) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (!(accept && (grant_id == IDW'(i))) && rsp_valid[i]) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
        case ({accept, rsp_fire})
            2'b10:   inflight_d = inflight_q + IFW'(1);
            2'b01:   inflight_d = inflight_q - IFW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // State registers; reset drops every in-flight tag so no stale result strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_q <= '0;
            tag_id_q    <= '0;
            cnt_q       <= '0;
            rr_q        <= IDW'(N_REQ - 1);
            inflight_q  <= '0;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_id_q    <= tag_id_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            inflight_q  <= inflight_d;
        end
    end

    a_rsp_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid));

    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt_chk
        a_cnt_max: assert property (@(posedge clk) disable iff (rst) cnt_q[g] <= CW'(MAX_OUT));
        a_cnt_min: assert property (@(posedge clk) disable iff (rst) !(rsp_valid[g] && (cnt_q[g] == '0)));
    end

endmodule

// File: tb/tb_complex_mult_sched.sv
// Directed bench for complex_mult_sched with a behavioural pipelined multiplier.
module tb_complex_mult_sched;

    localparam int N_REQ    = 4;
    localparam int PIPE_NUM = 10;
    localparam int MAX_OUT  = 4;
    localparam int IDW      = 2;
    localparam int IFW      = 5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   stall;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0][31:0] req_a;
    logic [N_REQ-1:0][31:0] req_b;
    logic [N_REQ-1:0]       req_ready;
    logic                   mult_en;
    logic [31:0]            mult_a;
    logic [31:0]            mult_b;
    logic [63:0]            mult_z;
    logic [N_REQ-1:0]       rsp_valid;
    logic [IDW-1:0]         rsp_id;
    logic [63:0]            rsp_z;
    logic [IFW-1:0]         inflight;

    complex_mult_sched #(
        .N_REQ(N_REQ), .PIPE_NUM(PIPE_NUM), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mult_en(mult_en), .mult_a(mult_a), .mult_b(mult_b), .mult_z(mult_z),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z), .inflight(inflight)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: PIPE_NUM stages, holds when en is low
    function automatic logic [63:0] cmul(input logic [31:0] a, input logic [31:0] b);
        int ar, ai, br, bi, zr, zi;
        ar = int'($signed(a[31:16]));
        ai = int'($signed(a[15:0]));
        br = int'($signed(b[31:16]));
        bi = int'($signed(b[15:0]));
        zr = ar * br - ai * bi;
        zi = ar * bi + ai * br;
        return {32'(zr), 32'(zi)};
    endfunction

    logic [PIPE_NUM-1:0][63:0] mpipe = '0;
    always @(posedge clk) begin
        if (mult_en) begin
            for (int s = PIPE_NUM - 1; s > 0; s--) mpipe[s] <= mpipe[s-1];
            mpipe[0] <= cmul(mult_a, mult_b);
        end
    end
    assign mult_z = mpipe[PIPE_NUM-1];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] z;
    } vec_t;
    vec_t tbl [N_REQ];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        stall     = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Wait (bounded) for the next result strobe, starting one cycle after accept
    task automatic wait_rsp(input string nm, input int exp_id, input logic [63:0] exp_z);
        int lat;
        bit seen;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= PIPE_NUM + 20) begin
            #1;
            if (rsp_valid != '0) seen = 1'b1;
            else begin
                step();
                lat++;
            end
        end
        check({nm, "_latency"}, 64'(lat), 64'(PIPE_NUM));
        check({nm, "_rsp_valid"}, 64'(rsp_valid), 64'(4'b0001 << exp_id));
        check({nm, "_rsp_id"}, 64'(rsp_id), 64'(exp_id));
        check({nm, "_rsp_z"}, rsp_z, exp_z);
    endtask

    initial begin
        int nrsp, bad, peak;
        int cyc0, cyc1, id0, id1;
        logic [63:0] z0, z1;
        logic [11:0] exp_ready;

        tbl[0] = '{a: {16'd3, 16'd4},         b: {16'd1, 16'hFFFE},      z: {32'd11, 32'hFFFF_FFFE}};
        tbl[1] = '{a: {16'd2, 16'd0},         b: {16'd5, 16'd7},         z: {32'd10, 32'd14}};
        tbl[2] = '{a: {16'hFFFF, 16'd1},      b: {16'd2, 16'd3},         z: {32'hFFFF_FFFB, 32'hFFFF_FFFF}};
        tbl[3] = '{a: {16'h8000, 16'h8000},   b: {16'h8000, 16'h8000},   z: {32'd0, 32'h8000_0000}};
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i] = tbl[i].a;
            req_b[i] = tbl[i].b;
        end

        // Reset state: ready held low by rst even with every requester valid
        stall     = 1'b0;
        rst       = 1'b1;
        req_valid = '1;
        step();
        #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_inflight", 64'(inflight), 64'd0);
        check("rst_mult_a", 64'(mult_a), 64'd0);
        check("rst_mult_en", 64'(mult_en), 64'd1);
        rst       = 1'b0;
        req_valid = '0;
        step();

        // 1: single request from r0
        do_reset();
        req_valid = 4'b0001;
        #1;
        check("t1_ready", 64'(req_ready), 64'b0001);
        check("t1_mult_a", 64'(mult_a), 64'(tbl[0].a));
        check("t1_mult_b", 64'(mult_b), 64'(tbl[0].b));
        step();
        req_valid = '0;
        #1;
        check("t1_bubble_a", 64'(mult_a), 64'd0);
        check("t1_inflight", 64'(inflight), 64'd1);
        wait_rsp("t1", 0, tbl[0].z);

        // 2: all requesters valid -> 0,1,2,3,0,... and results in the same order
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("t2_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            check("t2_mult_a", 64'(mult_a), 64'(tbl[k % 4].a));
            step();
        end
        req_valid = '0;
        for (int c = 8; c < 18; c++) begin
            #1;
            if (c == 8) check("t2_inflight", 64'(inflight), 64'd8);
            if (c < 10) check("t2_early_rsp", 64'(rsp_valid), 64'd0);
            else begin
                check("t2_rsp_valid", 64'(rsp_valid), 64'(4'b0001 << ((c - 10) % 4)));
                check("t2_rsp_z", rsp_z, tbl[(c - 10) % 4].z);
            end
            step();
        end

        // 3: r1 alone hits MAX_OUT, resumes the cycle after its first result
        do_reset();
        req_valid = 4'b0010;
        exp_ready = 12'b1000_0000_1111;
        peak      = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            check("t3_ready", 64'(req_ready), exp_ready[k] ? 64'b0010 : 64'd0);
            if (int'(inflight) > peak) peak = int'(inflight);
            step();
        end
        req_valid = '0;
        check("t3_peak", 64'(peak), 64'd4);
        for (int k = 0; k < 25; k++) step();
        #1;
        check("t3_drained", 64'(inflight), 64'd0);

        // 4: 3-cycle stall with two products in flight
        do_reset();
        req_valid = 4'b0001;
        step();
        req_valid = 4'b1000;
        #1;
        check("t4_grant_r3", 64'(req_ready), 64'b1000);
        step();
        req_valid = '0;
        step();
        for (int k = 0; k < 3; k++) begin
            stall     = 1'b1;
            req_valid = 4'b1111;
            #1;
            check("t4_stall_ready", 64'(req_ready), 64'd0);
            check("t4_stall_en", 64'(mult_en), 64'd0);
            check("t4_stall_rsp", 64'(rsp_valid), 64'd0);
            check("t4_stall_inflight", 64'(inflight), 64'd2);
            step();
        end
        stall     = 1'b0;
        req_valid = '0;
        nrsp = 0; cyc0 = 0; cyc1 = 0; id0 = 0; id1 = 0; z0 = '0; z1 = '0;
        for (int c = 6; c <= 30; c++) begin
            #1;
            if (rsp_valid != '0) begin
                if (nrsp == 0) begin cyc0 = c; id0 = int'(rsp_id); z0 = rsp_z; end
                if (nrsp == 1) begin cyc1 = c; id1 = int'(rsp_id); z1 = rsp_z; end
                nrsp++;
            end
            step();
        end
        check("t4_count", 64'(nrsp), 64'd2);
        check("t4_cycle0", 64'(cyc0), 64'd13);
        check("t4_id0", 64'(id0), 64'd0);
        check("t4_z0", z0, tbl[0].z);
        check("t4_cycle1", 64'(cyc1), 64'd14);
        check("t4_id1", 64'(id1), 64'd3);
        check("t4_z1", z1, tbl[3].z);

        // 5: reset mid-flight discards everything and restarts arbitration at r0
        do_reset();
        req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t5_grant", 64'(req_ready), 64'(4'b0001 << k));
            step();
        end
        req_valid = '0;
        for (int k = 0; k < 3; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (rsp_valid != '0) bad++;
            step();
        end
        check("t5_stale_rsp", 64'(bad), 64'd0);
        check("t5_inflight", 64'(inflight), 64'd0);
        req_valid = 4'b1111;
        #1;
        check("t5_first_grant", 64'(req_ready), 64'b0001);
        step();
        req_valid = '0;
        for (int k = 0; k < 15; k++) step();

        // 6: r2 accept and response in the same cycle at cnt=2
        do_reset();
        req_valid = 4'b0100;
        #1;
        check("t6_grant", 64'(req_ready), 64'b0100);
        step();
        step();
        req_valid = '0;
        for (int k = 2; k < 10; k++) step();
        req_valid = 4'b0100;
        #1;
        check("t6_rsp_same", 64'(rsp_valid), 64'b0100);
        check("t6_ready_same", 64'(req_ready), 64'b0100);
        check("t6_inflight_before", 64'(inflight), 64'd2);
        step();
        req_valid = '0;
        #1;
        check("t6_inflight_after", 64'(inflight), 64'd2);
        check("t6_rsp_next", 64'(rsp_valid), 64'b0100);
        step();
        #1;
        check("t6_inflight_drop", 64'(inflight), 64'd1);
        for (int k = 0; k < 12; k++) step();
        #1;
        check("t6_drained", 64'(inflight), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
